mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-low reset; one clock; sampled on the rising edge of clk.
REQ-004 l_s_typeM  in  8  one-hot {lw,lh,lhu,lb,lbu,sw,sh,sb}; all-zero means not a memory instruction.
REQ-005 validM  in  1  MEM-stage instruction valid (not a bubble).
REQ-006 flushM  in  1  MEM-stage instruction squashed by an exception or eret.
REQ-007 stall_extM  in  1  pipeline held by another cause; MEM instruction does not advance.
REQ-008 mem_addrM  in  32  effective address.
REQ-009 wdataM  in  32  store source (rt value).
REQ-010 data_req / data_wr  out  1/1  sram-like request and write flag.
REQ-011 data_size  out  2  0 = byte, 1 = half, 2 = word.
REQ-012 data_addr / data_wdata  out  32/32  request address and lane-replicated store data.
REQ-013 data_addr_ok / data_data_ok  in  1/1  address accepted; read data returned or write complete.
REQ-014 data_rdata  in  32  raw read word.
REQ-015 rdataM  out  32  extended load result.
REQ-016 adelM / adesM  out  1/1  load or store address error.
REQ-017 badvaddrM  out  32  faulting address.
REQ-018 mem_stallM  out  1  MEM stage must hold.

Function
REQ-019 Alignment: misaligned = (lw|sw) & addr[1:0]!=0, or (lh|lhu|sh) & addr[0]!=0; adelM = load & misaligned & validM; adesM = store & misaligned & validM; badvaddrM = mem_addrM; all combinational.
REQ-020 start = validM & !flushM & |l_s_typeM & !misaligned & state==IDLE; a misaligned access SHALL issue no request.
REQ-021 FSM states are IDLE, REQ, WAIT, DONE, DRAIN.
REQ-022 IDLE: on start, go to REQ and register addr, size, wr, and wdata.
REQ-023 Store data: sb replicates wdataM[7:0] x4; sh replicates wdataM[15:0] x2; sw passes wdataM unchanged.
REQ-024 REQ: data_req=1 with the registered fields stable.
REQ-025 REQ, addr_ok & data_ok in the same cycle: capture data and go to DONE.
REQ-026 REQ, addr_ok only: go to WAIT.
REQ-027 REQ, flushM & !addr_ok: drop data_req and return to IDLE.
REQ-028 WAIT: data_req=0; on data_ok, capture data and go to DONE.
REQ-029 WAIT & flushM & !data_ok: go to DRAIN.
REQ-030 WAIT & flushM & data_ok: go to IDLE and discard the data.
REQ-031 DRAIN: on data_ok, discard and go to IDLE; no new start is accepted in DRAIN.
REQ-032 DONE: rdataM held; when !stall_extM or flushM, go to IDLE.
REQ-033 Loads capture data_rdata on data_ok into rdataM, using byte lane addr[1:0] or half lane addr[1].
  - lb / lh: sign-extend.
  - lbu / lhu: zero-extend.
  - lw: unchanged.
  - Stores leave rdataM unchanged.
REQ-034 mem_stallM = start | REQ | WAIT | (DRAIN & validM & |l_s_typeM & !flushM); DONE and IDLE-without-start SHALL give 0.
REQ-035 Access latency SHALL be 1 cycle (IDLE to REQ) plus the bus wait; mem_stallM SHALL drop in the cycle after data_ok.
REQ-036 Only one outstanding request SHALL exist at any time.

Reset
REQ-037 While rst=0 at a clock edge: state=IDLE; data_req=0; data_wr=0; data_size=0; data_addr=0; data_wdata=0; rdataM=0.
REQ-038 Reset SHALL take priority over all events, including mid-REQ, mid-WAIT, and mid-DRAIN.
REQ-039 adelM, adesM, badvaddrM and mem_stallM SHALL follow their combinational definitions during reset.

Verification
REQ-040 lw at 0x00001000, addr_ok 2 cycles after req, data_ok 3 cycles later with 0x12345678 -> rdataM=0x12345678; mem_stallM high from the start cycle through the data_ok cycle, low the next cycle.
REQ-041 lb at 0x00001003 with data_rdata=0x80AABBCC -> rdataM=0xFFFFFF80; same access as lbu -> rdataM=0x00000080; lh at 0x1002 -> 0xFFFF80AA.
REQ-042 sh at 0x00002002 with wdataM=0x0000BEEF -> data_wr=1, data_size=1, data_wdata=0xBEEFBEEF, data_addr=0x00002002.
REQ-043 lw at 0x00001002 -> adelM=1, badvaddrM=0x00001002, data_req never asserted, mem_stallM=0; sh at 0x1001 -> adesM=1.
REQ-044 flushM during WAIT, then a new sw presented -> DRAIN; sw stalled; data_ok discarded with rdataM unchanged; sw request issued 1 cycle after IDLE is re-entered.
REQ-045 rst=0 during WAIT -> next cycle state IDLE, data_req=0, rdataM=0; a late data_ok is ignored.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: sram-like data bus between the MEM stage and memory
// master drives data_req/data_wr/data_size/data_addr/data_wdata; slave returns data_addr_ok/data_data_ok/data_rdata
interface mem_access_unit_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer onto an sram-like data bus
// clk/rst: clock and synchronous active-low reset
// l_s_typeM/validM/flushM/stall_extM/mem_addrM/wdataM: MEM-stage instruction inputs
// bus: sram-like master port; rdataM: extended load result
// adelM/adesM/badvaddrM: address error reporting; mem_stallM: MEM stage hold
module mem_access_unit (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              l_s_typeM,
  input  logic                    validM,
  input  logic                    flushM,
  input  logic                    stall_extM,
  input  logic [31:0]             mem_addrM,
  input  logic [31:0]             wdataM,
  mem_access_unit_if.master       bus,
  output logic [31:0]             rdataM,
  output logic                    adelM,
  output logic                    adesM,
  output logic [31:0]             badvaddrM,
  output logic                    mem_stallM
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
  state_t      state_q, state_d;
  logic        req_q, req_d, wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [4:0]  ld_q, ld_d;
  logic        is_load, is_store, misaligned, start;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  assign is_load    = |l_s_typeM[7:3];
  assign is_store   = |l_s_typeM[2:0];
  assign misaligned = ((l_s_typeM[7] | l_s_typeM[2]) & |mem_addrM[1:0]) |
                      ((l_s_typeM[6] | l_s_typeM[5] | l_s_typeM[1]) & mem_addrM[0]);
  assign adelM      = is_load & misaligned & validM;
  assign adesM      = is_store & misaligned & validM;
  assign badvaddrM  = mem_addrM;
  assign start      = validM & !flushM & |l_s_typeM & !misaligned & (state_q == IDLE);
  assign mem_stallM = start | (state_q == REQ) | (state_q == WAIT) |
                      ((state_q == DRAIN) & validM & |l_s_typeM & !flushM);
  // ld_q = {lw, lh, lhu, lb, lbu} of the access in flight
  assign byte_sel = bus.data_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
  assign load_val = ld_q[4] ? bus.data_rdata :
                    ld_q[3] ? {{16{half_sel[15]}}, half_sel} :
                    ld_q[2] ? {16'h0, half_sel} :
                    ld_q[1] ? {{24{byte_sel[7]}}, byte_sel} :
                              {24'h0, byte_sel};
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        addr_d  = mem_addrM;
        size_d  = (l_s_typeM[7] | l_s_typeM[2]) ? 2'd2 :
                  (l_s_typeM[6] | l_s_typeM[5] | l_s_typeM[1]) ? 2'd1 : 2'd0;
        wr_d    = is_store;
        wdata_d = l_s_typeM[0] ? {4{wdataM[7:0]}} :
                  l_s_typeM[1] ? {2{wdataM[15:0]}} : wdataM;
        ld_d    = l_s_typeM[7:3];
      end
      REQ:     state_d = bus.data_addr_ok ? (bus.data_data_ok ? DONE : WAIT) :
                         flushM ? IDLE : REQ;
      WAIT:    state_d = bus.data_data_ok ? (flushM ? IDLE : DONE) :
                         flushM ? DRAIN : WAIT;
      DRAIN:   state_d = bus.data_data_ok ? IDLE : DRAIN;
      DONE:    state_d = (!stall_extM || flushM) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // entering DONE is exactly the data_ok that carries a wanted result
    rdata_d = (state_d == DONE && state_q != DONE && |ld_q) ? load_val : rdata_q;
    req_d   = (state_d == REQ);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ld_q    <= 5'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ld_q    <= ld_d;
    end
  end
  assign bus.data_req   = req_q;
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign rdataM         = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven and sequence checks of mem_access_unit
module tb_mem_access_unit;
  localparam logic [7:0] LW = 8'h80, LH = 8'h40, LHU = 8'h20, LB = 8'h10, LBU = 8'h08,
                         SW = 8'h04, SH = 8'h02, SB = 8'h01;
  typedef struct {
    logic [7:0]  ty;
    logic [31:0] addr, wd, rd;
    int          al, dl;
    logic [31:0] er;
    logic        ewr;
    logic [1:0]  esz;
    logic [31:0] ewd;
    logic        eadel, eades;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  l_s_typeM = 8'h0;
  logic        validM = 1'b0, flushM = 1'b0, stall_extM = 1'b0;
  logic [31:0] mem_addrM = 32'h0, wdataM = 32'h0;
  logic [31:0] rdataM, badvaddrM;
  logic        adelM, adesM, mem_stallM;
  int          n_cmp = 0, n_err = 0;
  vec_t        vecs[14];
  mem_access_unit_if bus();
  mem_access_unit dut (
    .clk(clk), .rst(rst), .l_s_typeM(l_s_typeM), .validM(validM), .flushM(flushM),
    .stall_extM(stall_extM), .mem_addrM(mem_addrM), .wdataM(wdataM), .bus(bus),
    .rdataM(rdataM), .adelM(adelM), .adesM(adesM), .badvaddrM(badvaddrM),
    .mem_stallM(mem_stallM)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %0s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic bus_idle();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'hDEADBEEF;
  endtask
  task automatic run_vec(input int i, input vec_t v);
    logic seen, held;
    validM = 1'b1; l_s_typeM = v.ty; mem_addrM = v.addr; wdataM = v.wd;
    #1;
    chk($sformatf("v%0d adelM", i), 32'(adelM), 32'(v.eadel));
    chk($sformatf("v%0d adesM", i), 32'(adesM), 32'(v.eades));
    chk($sformatf("v%0d badvaddrM", i), badvaddrM, v.addr);
    if (v.eadel || v.eades) begin
      chk($sformatf("v%0d misaligned stall", i), 32'(mem_stallM), 32'd0);
      seen = 1'b0;
      repeat (3) begin @(negedge clk); seen |= bus.data_req; end
      chk($sformatf("v%0d misaligned no req", i), 32'(seen), 32'd0);
    end else begin
      chk($sformatf("v%0d start stall", i), 32'(mem_stallM), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d data_req", i), 32'(bus.data_req), 32'd1);
      chk($sformatf("v%0d data_wr", i), 32'(bus.data_wr), 32'(v.ewr));
      chk($sformatf("v%0d data_size", i), 32'(bus.data_size), 32'(v.esz));
      chk($sformatf("v%0d data_addr", i), bus.data_addr, v.addr);
      if (v.ewr) chk($sformatf("v%0d data_wdata", i), bus.data_wdata, v.ewd);
      held = 1'b1;
      repeat (v.al) begin @(negedge clk); held &= bus.data_req & mem_stallM; end
      chk($sformatf("v%0d req held", i), 32'(held), 32'd1);
      bus.data_addr_ok = 1'b1;
      if (v.dl == 0) begin bus.data_data_ok = 1'b1; bus.data_rdata = v.rd; end
      @(negedge clk);
      bus_idle();
      if (v.dl > 0) begin
        chk($sformatf("v%0d wait no req", i), 32'(bus.data_req), 32'd0);
        repeat (v.dl - 1) @(negedge clk);
        bus.data_data_ok = 1'b1; bus.data_rdata = v.rd;
        #1 chk($sformatf("v%0d data_ok stall", i), 32'(mem_stallM), 32'd1);
        @(negedge clk);
        bus_idle();
      end
      #1;
      chk($sformatf("v%0d done stall", i), 32'(mem_stallM), 32'd0);
      chk($sformatf("v%0d rdataM", i), rdataM, v.er);
    end
    validM = 1'b0; l_s_typeM = 8'h0;
    @(negedge clk);
  endtask
  initial begin
    vecs[0]  = '{LW,  32'h1000, 32'h0, 32'h12345678, 2, 3, 32'h12345678, 1'b0, 2'd2, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{LB,  32'h1003, 32'h0, 32'h80AABBCC, 0, 0, 32'hFFFFFF80, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{LBU, 32'h1003, 32'h0, 32'h80AABBCC, 1, 1, 32'h00000080, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{LH,  32'h1002, 32'h0, 32'h80AABBCC, 0, 2, 32'hFFFF80AA, 1'b0, 2'd1, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{LHU, 32'h1000, 32'h0, 32'h80AABBCC, 1, 0, 32'h0000BBCC, 1'b0, 2'd1, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{LB,  32'h1001, 32'h0, 32'h80AABBCC, 0, 1, 32'hFFFFFFBB, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0};
    vecs[6]  = '{LB,  32'h1002, 32'h0, 32'h80AABBCC, 0, 0, 32'hFFFFFFAA, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0};
    vecs[7]  = '{SH,  32'h2002, 32'h0000BEEF, 32'h99999999, 1, 1, 32'hFFFFFFAA, 1'b1, 2'd1, 32'hBEEFBEEF, 1'b0, 1'b0};
    vecs[8]  = '{SB,  32'h2001, 32'h123456A5, 32'h99999999, 0, 0, 32'hFFFFFFAA, 1'b1, 2'd0, 32'hA5A5A5A5, 1'b0, 1'b0};
    vecs[9]  = '{SW,  32'h2004, 32'hCAFEF00D, 32'h99999999, 2, 0, 32'hFFFFFFAA, 1'b1, 2'd2, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[10] = '{LW,  32'h1002, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0};
    vecs[11] = '{SH,  32'h1001, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1};
    vecs[12] = '{LHU, 32'h1003, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0};
    vecs[13] = '{SW,  32'h2006, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1};
    bus_idle();
    // reset with a misaligned lw presented: error flags stay combinational
    rst = 1'b0; validM = 1'b1; l_s_typeM = LW; mem_addrM = 32'h1002;
    repeat (2) @(negedge clk);
    #1;
    chk("rst adelM", 32'(adelM), 32'd1);
    chk("rst stall", 32'(mem_stallM), 32'd0);
    chk("rst data_req", 32'(bus.data_req), 32'd0);
    chk("rst data_wr", 32'(bus.data_wr), 32'd0);
    chk("rst data_size", 32'(bus.data_size), 32'd0);
    chk("rst data_addr", bus.data_addr, 32'h0);
    chk("rst data_wdata", bus.data_wdata, 32'h0);
    chk("rst rdataM", rdataM, 32'h0);
    @(negedge clk);
    rst = 1'b1; validM = 1'b0; l_s_typeM = 8'h0;
    @(negedge clk);
    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);
    // DONE held by an external stall: result held, no new request
    stall_extM = 1'b1; validM = 1'b1; l_s_typeM = LW; mem_addrM = 32'h1004;
    @(negedge clk);
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0BADCAFE;
    @(negedge clk);
    bus_idle();
    #1 chk("hold rdataM", rdataM, 32'h0BADCAFE);
    @(negedge clk);
    #1;
    chk("hold stall", 32'(mem_stallM), 32'd0);
    chk("hold no req", 32'(bus.data_req), 32'd0);
    stall_extM = 1'b0;
    @(negedge clk);
    validM = 1'b0; l_s_typeM = 8'h0;
    @(negedge clk);
    chk("hold release no req", 32'(bus.data_req), 32'd0);
    // flush while REQ without addr_ok drops the request
    validM = 1'b1; l_s_typeM = LW; mem_addrM = 32'h1008;
    @(negedge clk);
    chk("flushreq req", 32'(bus.data_req), 32'd1);
    flushM = 1'b1;
    @(negedge clk);
    flushM = 1'b0; validM = 1'b0; l_s_typeM = 8'h0;
    #1;
    chk("flushreq dropped", 32'(bus.data_req), 32'd0);
    chk("flushreq stall", 32'(mem_stallM), 32'd0);
    @(negedge clk);
    // flush in WAIT -> DRAIN; following sw stalls until the stale data_ok
    validM = 1'b1; l_s_typeM = LW; mem_addrM = 32'h100C;
    @(negedge clk);
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus_idle();
    flushM = 1'b1;
    @(negedge clk);
    flushM = 1'b0; l_s_typeM = SW; mem_addrM = 32'h3000; wdataM = 32'h11223344;
    #1 chk("drain stall", 32'(mem_stallM), 32'd1);
    @(negedge clk);
    chk("drain no req", 32'(bus.data_req), 32'd0);
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55555555;
    #1 chk("drain data_ok stall", 32'(mem_stallM), 32'd1);
    @(negedge clk);
    bus_idle();
    #1;
    chk("drain rdataM kept", rdataM, 32'h0BADCAFE);
    chk("drain idle no req", 32'(bus.data_req), 32'd0);
    chk("drain idle start stall", 32'(mem_stallM), 32'd1);
    @(negedge clk);
    chk("drain sw req", 32'(bus.data_req), 32'd1);
    chk("drain sw wr", 32'(bus.data_wr), 32'd1);
    chk("drain sw addr", bus.data_addr, 32'h3000);
    chk("drain sw wdata", bus.data_wdata, 32'h11223344);
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1;
    @(negedge clk);
    bus_idle();
    #1 chk("drain sw done stall", 32'(mem_stallM), 32'd0);
    validM = 1'b0; l_s_typeM = 8'h0;
    @(negedge clk);
    // reset in WAIT; the late data_ok must be ignored
    validM = 1'b1; l_s_typeM = LW; mem_addrM = 32'h1010;
    @(negedge clk);
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus_idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; validM = 1'b0; l_s_typeM = 8'h0;
    #1;
    chk("wrst data_req", 32'(bus.data_req), 32'd0);
    chk("wrst rdataM", rdataM, 32'h0);
    chk("wrst stall", 32'(mem_stallM), 32'd0);
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h77777777;
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    chk("wrst late rdataM", rdataM, 32'h0);
    chk("wrst late req", 32'(bus.data_req), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
